image_conv3x3: RTL and testbench

//  Pipelined 3x3 convolution stage that sits directly downstream of the kernel

---
 rtl/image_conv3x3.sv | 202 ++++++++++++++++++++
 tb/tb_image_conv3x3.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_conv3x3.sv
// image_conv3x3
//   Pipelined 3x3 convolution stage placed directly after the 3x3 kernel
//   (window) stage. Each beat carries a flattened 3x3 window plus a data
//   type tag. Pixel beats are filtered with a signed coefficient bank, then
//   right-shifted and clamped. Every beat has a fixed latency of three
//   register stages. Coefficients are written into a pending bank and copied
//   into the active bank on each FRAME_START beat, so a frame never sees a
//   mix of old and new coefficients.
//
// Optional feature macro: IMAGE_CONV_ABS_EN
//   When defined, the magnitude of the sum is taken before shift and clamp
//   (edge kernels give magnitude output). When undefined, negative results
//   clamp to 0.
//
// Ports
//   clk       pixel clock
//   resetb    asynchronous active-low reset
//   enable    1 = filter, 0 = bypass centre pixel; captured at frame start
//   cfg_we    config write strobe
//   cfg_addr  0-8 coef[r*3+c], 9 shift (low 4 bits), 10-15 ignored
//   cfg_data  config write data
//   dvi       input valid
//   dtypei    input data type
//   kerneli   window, [(r*3+c)*DATA_WIDTH +: DATA_WIDTH]; r0 oldest row, c0 oldest col
//   dvo       output valid
//   dtypeo    output data type
//   datao     filtered pixel (centre pixel on non-pixel beats or in bypass)
module image_conv3x3 #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEF_WIDTH  = 8,
    parameter int DTYPE_WIDTH = 4,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 'h1,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 'h8
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_addr,
    input  logic [COEF_WIDTH-1:0]   cfg_data,
    input  logic                    dvi,
    input  logic [DTYPE_WIDTH-1:0]  dtypei,
    input  logic [9*DATA_WIDTH-1:0] kerneli,
    output logic                    dvo,
    output logic [DTYPE_WIDTH-1:0]  dtypeo,
    output logic [DATA_WIDTH-1:0]   datao
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH + 1; // product width
    localparam int SW = PW + 4;                      // sum width
    localparam int AW = SW + 1;                      // magnitude width

    // Coefficient banks
    logic signed [COEF_WIDTH-1:0] pend_coef [9];
    logic signed [COEF_WIDTH-1:0] act_coef  [9];
    logic [3:0]                   pend_shift;
    logic [3:0]                   act_shift;
    logic                         act_en;
    logic                         in_frame;

    // Stage 1
    logic                         v1;
    logic [DTYPE_WIDTH-1:0]       t1;
    logic [DATA_WIDTH-1:0]        c1;
    logic                         f1;
    logic [3:0]                   sh1;
    logic signed [PW-1:0]         prod1 [9];

    // Stage 2
    logic                         v2;
    logic [DTYPE_WIDTH-1:0]       t2;
    logic [DATA_WIDTH-1:0]        c2;
    logic                         f2;
    logic [3:0]                   sh2;
    logic signed [SW-1:0]         sum2;

    // Combinational
    logic                         fs;
    logic                         pass;
    logic                         is_pix;
    logic                         eff_en;
    logic [3:0]                   eff_shift;
    logic signed [PW-1:0]         prod_c [9];
    logic signed [SW-1:0]         sum_c;
    logic signed [AW-1:0]         mag;
    logic signed [AW-1:0]         shifted;
    logic [DATA_WIDTH-1:0]        clamped;

    assign fs     = dvi && (dtypei == DTYPE_FRAME_START);
    // After reset nothing is emitted until a FRAME_START opens a new frame.
    assign pass   = dvi && (in_frame || fs);
    assign is_pix = |(dtypei & DTYPE_PIXEL_MASK);

    // The FRAME_START beat itself already uses the bank it is loading.
    assign eff_en    = fs ? enable     : act_en;
    assign eff_shift = fs ? pend_shift : act_shift;

    always_comb begin
        for (int unsigned k = 0; k < 9; k++) begin
            prod_c[k] = '0;
            prod_c[k] = PW'(fs ? pend_coef[k] : act_coef[k]) *
                        PW'($signed({1'b0, kerneli[k*DATA_WIDTH +: DATA_WIDTH]}));
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            sum_c = sum_c + SW'(prod1[k]);
        end
    end

    always_comb begin
        mag = AW'(sum2);
`ifdef IMAGE_CONV_ABS_EN
        if (sum2 < 0) begin
            mag = -AW'(sum2);
        end
`endif
        shifted = mag >>> sh2;
        if (shifted[AW-1]) begin
            clamped = '0;
        end else if (|shifted[AW-2:DATA_WIDTH]) begin
            clamped = '1;
        end else begin
            clamped = shifted[DATA_WIDTH-1:0];
        end
    end

    // Configuration and frame-start bank transfer
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int unsigned k = 0; k < 9; k++) begin
                pend_coef[k] <= (k == 4) ? COEF_WIDTH'(1) : '0;
                act_coef[k]  <= (k == 4) ? COEF_WIDTH'(1) : '0;
            end
            pend_shift <= '0;
            act_shift  <= '0;
            act_en     <= 1'b0;
            in_frame   <= 1'b0;
        end else begin
            if (fs) begin
                act_coef  <= pend_coef;
                act_shift <= pend_shift;
                act_en    <= enable;
                in_frame  <= 1'b1;
            end
            if (cfg_we) begin
                for (int unsigned k = 0; k < 9; k++) begin
                    if (cfg_addr == 4'(k)) begin
                        pend_coef[k] <= cfg_data;
                    end
                end
                if (cfg_addr == 4'd9) begin
                    pend_shift <= cfg_data[3:0];
                end
            end
        end
    end

    // Three-stage datapath
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            v1     <= 1'b0;
            t1     <= '0;
            c1     <= '0;
            f1     <= 1'b0;
            sh1    <= '0;
            for (int unsigned k = 0; k < 9; k++) begin
                prod1[k] <= '0;
            end
            v2     <= 1'b0;
            t2     <= '0;
            c2     <= '0;
            f2     <= 1'b0;
            sh2    <= '0;
            sum2   <= '0;
            dvo    <= 1'b0;
            dtypeo <= '0;
            datao  <= '0;
        end else begin
            v1     <= pass;
            t1     <= dtypei;
            c1     <= kerneli[4*DATA_WIDTH +: DATA_WIDTH];
            f1     <= eff_en && is_pix;
            sh1    <= eff_shift;
            prod1  <= prod_c;

            v2     <= v1;
            t2     <= t1;
            c2     <= c1;
            f2     <= f1;
            sh2    <= sh1;
            sum2   <= sum_c;

            dvo    <= v2;
            dtypeo <= t2;
            datao  <= f2 ? clamped : c2;
        end
    end

endmodule

// File: tb/tb_image_conv3x3.sv
// tb_image_conv3x3
//   Directed bench for image_conv3x3. Beats are listed in a table together
//   with the output each one must produce three register stages later; the
//   runner drives one beat per clock and compares the delayed result. Reset
//   behaviour is exercised by hand-written sequences.
module tb_image_conv3x3;

    localparam logic [3:0] T_FS   = 4'h1;
    localparam logic [3:0] T_FE   = 4'h2;
    localparam logic [3:0] T_RS   = 4'h3;
    localparam logic [3:0] T_RE   = 4'h4;
    localparam logic [3:0] T_PIX  = 4'h8;

    logic        clk;
    logic        resetb;
    logic        enable;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        dvi;
    logic [3:0]  dtypei;
    logic [71:0] kerneli;
    logic        dvo;
    logic [3:0]  dtypeo;
    logic [7:0]  datao;

    int n_cmp = 0;
    int n_bad = 0;

    image_conv3x3 #(
        .DATA_WIDTH(8),
        .COEF_WIDTH(8),
        .DTYPE_WIDTH(4),
        .DTYPE_FRAME_START(T_FS),
        .DTYPE_PIXEL_MASK(T_PIX)
    ) dut (
        .clk(clk),
        .resetb(resetb),
        .enable(enable),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .dvi(dvi),
        .dtypei(dtypei),
        .kerneli(kerneli),
        .dvo(dvo),
        .dtypeo(dtypeo),
        .datao(datao)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dvi;
        logic [3:0]  dtype;
        logic [71:0] win;
        logic        en;
        logic        cwe;
        logic [3:0]  caddr;
        logic [7:0]  cdata;
        logic        exp_dvo;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [71:0] win(input logic [7:0] nb, input logic [7:0] ctr);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = nb;
        w[4*8 +: 8] = ctr;
        return w;
    endfunction

    task automatic add(input logic v, input logic [3:0] t, input logic [71:0] w,
                       input logic en, input logic we, input logic [3:0] a,
                       input logic [7:0] d, input logic ev, input logic [7:0] ed);
        vec_t r;
        r.dvi = v; r.dtype = t; r.win = w; r.en = en;
        r.cwe = we; r.caddr = a; r.cdata = d;
        r.exp_dvo = ev; r.exp_data = ed;
        tbl.push_back(r);
    endtask

    task automatic beat(input logic [3:0] t, input logic [71:0] w, input logic en,
                        input logic ev, input logic [7:0] ed);
        add(1'b1, t, w, en, 1'b0, 4'd0, 8'd0, ev, ed);
    endtask

    task automatic cfg(input logic [3:0] a, input logic [7:0] d);
        add(1'b0, 4'h0, '0, 1'b0, 1'b1, a, d, 1'b0, 8'd0);
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        dvi = 1'b0; dtypei = '0; kerneli = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    endtask

    task automatic run_table(input string name);
        int n;
        n = tbl.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                dvi = tbl[i].dvi; dtypei = tbl[i].dtype; kerneli = tbl[i].win;
                enable = tbl[i].en; cfg_we = tbl[i].cwe;
                cfg_addr = tbl[i].caddr; cfg_data = tbl[i].cdata;
            end else begin
                idle();
            end
            @(posedge clk); #1;
            if (i >= 2) begin
                cmp({name, ".dvo"}, {7'd0, dvo}, {7'd0, tbl[i-2].exp_dvo});
                if (tbl[i-2].exp_dvo) begin
                    cmp({name, ".dtypeo"}, {4'd0, dtypeo}, {4'd0, tbl[i-2].dtype});
                    cmp({name, ".datao"}, datao, tbl[i-2].exp_data);
                end
            end
        end
        idle();
        tbl.delete();
    endtask

    logic [7:0] lap_neg;  // Laplacian, centre 0 neighbours 255
    logic [7:0] lap_m8;   // Laplacian, sum -8

    initial begin
`ifdef IMAGE_CONV_ABS_EN
        lap_neg = 8'd255;
        lap_m8  = 8'd8;
`else
        lap_neg = 8'd0;
        lap_m8  = 8'd0;
`endif
        resetb = 1'b0; enable = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.dvo", {7'd0, dvo}, 8'd0);
        cmp("reset.dtypeo", {4'd0, dtypeo}, 8'd0);
        cmp("reset.datao", datao, 8'd0);
        @(negedge clk);
        resetb = 1'b1;
        @(posedge clk); #1;

        // Identity bank, headers and bubbles pass through with fixed latency
        beat(T_FS,  win(8'h37, 8'hA5), 1'b1, 1'b1, 8'hA5);
        beat(T_PIX, win(8'h37, 8'hA5), 1'b1, 1'b1, 8'hA5);
        add(1'b0, T_PIX, win(8'h37, 8'h55), 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 8'd0);
        beat(T_RS,  win(8'h00, 8'h12), 1'b1, 1'b1, 8'h12);
        beat(T_PIX, win(8'h37, 8'hA5), 1'b1, 1'b1, 8'hA5);
        add(1'b0, T_RE, win(8'h00, 8'h99), 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 8'd0);
        add(1'b0, T_RE, win(8'h00, 8'h98), 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 8'd0);
        beat(T_RE,  win(8'h00, 8'h34), 1'b1, 1'b1, 8'h34);
        beat(T_PIX, win(8'h37, 8'hA5), 1'b1, 1'b1, 8'hA5);
        run_table("ident");

        // Box filter: all ones, shift 3
        for (int k = 0; k < 9; k++) cfg(4'(k), 8'd1);
        cfg(4'd9, 8'd3);
        beat(T_FS,  win(8'd0, 8'd0), 1'b1, 1'b1, 8'd0);
        beat(T_PIX, win(8'd100, 8'd100), 1'b1, 1'b1, 8'd112);
        beat(T_PIX, win(8'd255, 8'd255), 1'b1, 1'b1, 8'd255);
        beat(T_PIX, win(8'd8, 8'd8), 1'b1, 1'b1, 8'd9);
        beat(T_FE,  win(8'd100, 8'd77), 1'b1, 1'b1, 8'd77);
        run_table("box");

        // Laplacian, shift 0
        for (int k = 0; k < 9; k++) cfg(4'(k), (k == 4) ? 8'd8 : 8'hFF);
        cfg(4'd9, 8'd0);
        beat(T_FS,  win(8'd0, 8'd0), 1'b1, 1'b1, 8'd0);
        beat(T_PIX, win(8'd0, 8'd255), 1'b1, 1'b1, 8'd255);
        beat(T_PIX, win(8'd255, 8'd0), 1'b1, 1'b1, lap_neg);
        beat(T_PIX, win(8'd9, 8'd10), 1'b1, 1'b1, 8'd8);
        beat(T_PIX, win(8'd10, 8'd9), 1'b1, 1'b1, lap_m8);
        run_table("lap");

        // Mid-frame write must not disturb the current frame
        for (int k = 0; k < 9; k++) cfg(4'(k), 8'd1);
        beat(T_PIX, win(8'd9, 8'd10), 1'b1, 1'b1, 8'd8);
        beat(T_RE,  win(8'd9, 8'd44), 1'b1, 1'b1, 8'd44);
        run_table("midwr");

        // Write coincident with FRAME_START lands one frame later
        add(1'b1, T_FS, win(8'd10, 8'd10), 1'b1, 1'b1, 4'd9, 8'd2, 1'b1, 8'd10);
        beat(T_PIX, win(8'd10, 8'd10), 1'b1, 1'b1, 8'd90);
        beat(T_FS,  win(8'd10, 8'd10), 1'b1, 1'b1, 8'd10);
        beat(T_PIX, win(8'd10, 8'd10), 1'b1, 1'b1, 8'd22);
        run_table("fswr");

        // Bypass captured at frame start; enable change mid-frame ignored
        beat(T_FS,  win(8'd10, 8'h33), 1'b0, 1'b1, 8'h33);
        beat(T_PIX, win(8'd10, 8'h33), 1'b0, 1'b1, 8'h33);
        beat(T_PIX, win(8'd10, 8'h33), 1'b1, 1'b1, 8'h33);
        run_table("bypass");

        // Reset mid-row
        enable = 1'b1;
        dvi = 1'b1; dtypei = T_FS; kerneli = win(8'd100, 8'd200);
        @(posedge clk); #1;
        dtypei = T_PIX;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmp("prerst.dvo", {7'd0, dvo}, 8'd1);
        cmp("prerst.datao", datao, 8'd200);
        @(posedge clk); #1;
        cmp("prerst.filt", datao, 8'd250);
        resetb = 1'b0;
        #1;
        cmp("rst.dvo", {7'd0, dvo}, 8'd0);
        cmp("rst.datao", datao, 8'd0);
        @(negedge clk);
        resetb = 1'b1;
        idle();
        @(posedge clk); #1;
        beat(T_PIX, win(8'd100, 8'd200), 1'b1, 1'b0, 8'd0);
        beat(T_RS,  win(8'd100, 8'd200), 1'b1, 1'b0, 8'd0);
        beat(T_PIX, win(8'd100, 8'd200), 1'b1, 1'b0, 8'd0);
        beat(T_FS,  win(8'd100, 8'd201), 1'b1, 1'b1, 8'd201);
        beat(T_PIX, win(8'd100, 8'd200), 1'b1, 1'b1, 8'd200);
        run_table("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
